// File: rtl/trace_pkg.sv
// Shared types for the commit trace checker: trace record, error codes,
// checker state and the field-priority compare helper.
// Optional feature macro: TRACE_CHECK_DATA_EN (compare written data, enables err_code 4).
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } trace_rec_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PC       = 3'd1,
    ERR_INST     = 3'd2,
    ERR_WERD     = 3'd3,
    ERR_DATA     = 3'd4,
    ERR_OVERFLOW = 3'd5
  } trace_err_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } trace_state_e;

  // First differing field in priority pc > inst > we/rd > data.
  // rd only matters when the register file is written; same for data.
  function automatic trace_err_e compare_rec(input trace_rec_t got, input trace_rec_t want);
    trace_err_e code;
    code = ERR_NONE;
    if (got.pc != want.pc)
      code = ERR_PC;
    else if (got.inst != want.inst)
      code = ERR_INST;
    else if ((got.we != want.we) || (got.we && (got.rd != want.rd)))
      code = ERR_WERD;
`ifdef TRACE_CHECK_DATA_EN
    else if (got.we && (got.data != want.data))
      code = ERR_DATA;
`endif
    return code;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records with full/empty, occupancy count and
// same-cycle push+pop. DEPTH must be a power of two, at least 2.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  trace_rec_t             i_data,
  input  logic                   i_pop,
  output trace_rec_t             o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW:0]     CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Record storage, written on push.
  // NOTE: the array has no reset; pointers and count decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/commit_trace_checker.sv
// Snoops the CPU commit port, buffers retired instructions and compares them
// in order against golden trace records. Ends in PASS on two consecutive
// all-zero instructions, or FAIL on the first mismatch / buffer overflow.
// Optional feature macro: TRACE_CHECK_DATA_EN (compare written data).
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic             commit_we,
  input  logic [4:0]       commit_rd,
  input  logic [31:0]      commit_data,
  output logic             cpu_stall,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [31:0]      exp_pc,
  input  logic [31:0]      exp_inst,
  input  logic             exp_we,
  input  logic [4:0]       exp_rd,
  input  logic [31:0]      exp_data,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] err_index,
  output logic [CNT_W-1:0] check_count
);

  localparam int               OCC_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  trace_state_e     r_state;
  trace_state_e     w_state_next;
  logic             r_prev_zero;
  trace_err_e       r_err_code;
  logic [CNT_W-1:0] r_err_index;
  logic [CNT_W-1:0] r_check_count;

  trace_rec_t       w_commit_rec;
  trace_rec_t       w_exp_rec;
  trace_rec_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic [OCC_W-1:0] w_count;

  logic             w_run;
  logic             w_term;
  logic             w_compare;
  logic             w_mismatch;
  logic             w_overflow;
  logic             w_push;
  logic             w_pop;
  trace_err_e       w_cmp_code;

  assign w_commit_rec = '{pc: commit_pc, inst: commit_inst, we: commit_we,
                          rd: commit_rd, data: commit_data};
  assign w_exp_rec    = '{pc: exp_pc, inst: exp_inst, we: exp_we,
                          rd: exp_rd, data: exp_data};

`ifndef TRACE_CHECK_DATA_EN
  // Data fields travel with the record but are not checked in this build.
  logic w_unused_data;
  assign w_unused_data = ^{w_head.data, w_exp_rec.data};
`endif

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_commit_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Second all-zero instruction in a row ends the program; it needs no golden record.
  assign w_run      = (r_state == ST_RUN);
  assign w_term     = w_run && !w_empty && (w_head.inst == '0) && r_prev_zero;
  assign w_compare  = w_run && !w_empty && exp_valid && !w_term;
  assign w_cmp_code = compare_rec(w_head, w_exp_rec);
  assign w_mismatch = w_compare && (w_cmp_code != ERR_NONE);
  assign w_overflow = w_run && commit_valid && w_full;
  assign w_push     = w_run && commit_valid && !w_full;
  assign w_pop      = w_compare || w_term;

  assign cpu_stall   = w_run && w_full;
  assign exp_ready   = w_compare;
  assign done        = (r_state != ST_RUN);
  assign pass        = (r_state == ST_PASS);
  assign err_code    = r_err_code;
  assign err_index   = r_err_index;
  assign check_count = r_check_count;

  // Next-state: a mismatch outranks an overflow, which outranks termination.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    if (w_run) begin
      if (w_mismatch || w_overflow) w_state_next = ST_FAIL;
      else if (w_term)              w_state_next = ST_PASS;
    end
  end

  // State register; PASS and FAIL hold until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // Compare counter and the "previous compared inst was zero" flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_check_count <= '0;
      r_prev_zero   <= 1'b0;
    end else if (w_compare && !w_mismatch) begin
      r_check_count <= r_check_count + CNT_ONE;
      r_prev_zero   <= (w_head.inst == '0);
    end
  end

  // Error report captured on the deciding edge; an overflow names the dropped commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_code  <= ERR_NONE;
      r_err_index <= '0;
    end else if (w_mismatch) begin
      r_err_code  <= w_cmp_code;
      r_err_index <= r_check_count;
    end else if (w_overflow) begin
      r_err_code  <= ERR_OVERFLOW;
      r_err_index <= r_check_count + CNT_W'(w_count);
    end
  end

endmodule
